// File: rtl/reg_dump_reader.sv
// Walks the register file two registers per read cycle and streams (addr, data) words over valid/ready.
// Optional REG_DUMP_SKIP_ZERO_EN drops zero-valued words and adds a DumpCount output.
module reg_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rs1,
  output logic [ADDR_W-1:0] rs2,
  input  logic [DATA_W-1:0] Ru1,
  input  logic [DATA_W-1:0] Ru2,
  output logic [ADDR_W-1:0] DumpAddr,
  output logic [DATA_W-1:0] DumpData,
  output logic              DumpValid,
  input  logic              DumpReady,
  output logic              busy,
  output logic              done
`ifdef REG_DUMP_SKIP_ZERO_EN
  ,output logic [ADDR_W:0]  DumpCount
`endif
);

  typedef enum logic [2:0] {IDLE, READ, SEND_A, SEND_B, FIN} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS/2 - 1);
  localparam logic [ADDR_W-1:0] TWO  = ADDR_W'(2);

  state_t            state;
  logic [ADDR_W-1:0] k;
  logic [DATA_W-1:0] HoldB;
  logic              last_pair;

  assign last_pair = (k == LAST);
  assign busy      = (state != IDLE);

  // DumpData doubles as the holding register for the even word, so only HoldB is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      HoldB     <= '0;
      rs1       <= '0;
      rs2       <= '0;
      DumpAddr  <= '0;
      DumpData  <= '0;
      DumpValid <= 1'b0;
      done      <= 1'b0;
`ifdef REG_DUMP_SKIP_ZERO_EN
      DumpCount <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= READ;
            k     <= '0;
            rs1   <= '0;
            rs2   <= ADDR_W'(1);
`ifdef REG_DUMP_SKIP_ZERO_EN
            DumpCount <= '0;
`endif
          end
        end

        READ: begin
          HoldB <= Ru2;
`ifdef REG_DUMP_SKIP_ZERO_EN
          if (Ru1 != '0) begin
            state     <= SEND_A;
            DumpValid <= 1'b1;
            DumpAddr  <= rs1;
            DumpData  <= Ru1;
          end else if (Ru2 != '0) begin
            state     <= SEND_B;
            DumpValid <= 1'b1;
            DumpAddr  <= rs2;
            DumpData  <= Ru2;
          end else if (last_pair) begin
            state <= FIN;
          end else begin
            state <= READ;
            k     <= k + ADDR_W'(1);
            rs1   <= rs1 + TWO;
            rs2   <= rs2 + TWO;
          end
`else
          state     <= SEND_A;
          DumpValid <= 1'b1;
          DumpAddr  <= rs1;
          DumpData  <= Ru1;
`endif
        end

        SEND_A: begin
          if (DumpReady) begin
`ifdef REG_DUMP_SKIP_ZERO_EN
            DumpCount <= DumpCount + (ADDR_W+1)'(1);
            if (HoldB != '0) begin
              state    <= SEND_B;
              DumpAddr <= rs2;
              DumpData <= HoldB;
            end else begin
              DumpValid <= 1'b0;
              if (last_pair) state <= FIN;
              else begin
                state <= READ;
                k     <= k + ADDR_W'(1);
                rs1   <= rs1 + TWO;
                rs2   <= rs2 + TWO;
              end
            end
`else
            state    <= SEND_B;
            DumpAddr <= rs2;
            DumpData <= HoldB;
`endif
          end
        end

        SEND_B: begin
          if (DumpReady) begin
            DumpValid <= 1'b0;
`ifdef REG_DUMP_SKIP_ZERO_EN
            DumpCount <= DumpCount + (ADDR_W+1)'(1);
`endif
            if (last_pair) state <= FIN;
            else begin
              state <= READ;
              k     <= k + ADDR_W'(1);
              rs1   <= rs1 + TWO;
              rs2   <= rs2 + TWO;
            end
          end
        end

        FIN: begin
          // First FIN cycle raises done; the second drops it and returns to IDLE.
          if (!done) begin
            done <= 1'b1;
          end else begin
            done  <= 1'b0;
            state <= IDLE;
            k     <= '0;
            rs1   <= '0;
            rs2   <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Randomized self-checking bench for reg_dump_reader; register unit modelled as a combinational array.
module tb_reg_dump_reader;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, DumpReady = 1'b0;
  logic [AW-1:0] rs1, rs2, DumpAddr;
  logic [DW-1:0] Ru1, Ru2, DumpData;
  logic DumpValid, busy, done;
`ifdef REG_DUMP_SKIP_ZERO_EN
  logic [AW:0] DumpCount;
`endif

  logic [DW-1:0] regs [NR];
  assign Ru1 = regs[rs1];
  assign Ru2 = regs[rs2];

  reg_dump_reader #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rs1(rs1), .rs2(rs2), .Ru1(Ru1), .Ru2(Ru2),
    .DumpAddr(DumpAddr), .DumpData(DumpData), .DumpValid(DumpValid), .DumpReady(DumpReady),
    .busy(busy), .done(done)
`ifdef REG_DUMP_SKIP_ZERO_EN
    , .DumpCount(DumpCount)
`endif
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int checks = 0, errors = 0;

  logic [AW-1:0] got_a[$], exp_a[$];
  logic [DW-1:0] got_d[$], exp_d[$];
  int  done_cnt, done_rel, stab_err;
  bit  timed_out;

  // Reference: every register in address order, zero words dropped when skipping is enabled.
  task automatic build_exp(input logic [DW-1:0] snap [NR]);
    exp_a.delete(); exp_d.delete();
    for (int i = 0; i < NR; i++) begin
`ifdef REG_DUMP_SKIP_ZERO_EN
      if (snap[i] == '0) continue;
`endif
      exp_a.push_back(AW'(i));
      exp_d.push_back(snap[i]);
    end
  endtask

  task automatic run_dump(input int pct, input int rw1, input int rw2,
                          input int wr_idx, input logic [DW-1:0] wr_val);
    int e0;
    bit seen_busy, written, pv;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    got_a.delete(); got_d.delete();
    done_cnt = 0; done_rel = -1; stab_err = 0; timed_out = 1'b0;
    seen_busy = 0; written = 0; pv = 0; pa = '0; pd = '0;
    @(negedge clk);
    start = 1'b1; DumpReady = 1'b0;
    e0 = edge_cnt + 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) seen_busy = 1;
      if (done) begin done_cnt++; done_rel = edge_cnt - e0; end
      if (pv && !(DumpValid && DumpAddr == pa && DumpData == pd)) stab_err++;
      if (seen_busy && !busy) return;
      if (wr_idx >= 0 && !written && DumpValid && DumpAddr == AW'(wr_idx)) begin
        regs[wr_idx] = wr_val;
        written = 1;
      end
      DumpReady = ($urandom_range(99) < pct);
      if (busy && (got_a.size() == rw1 || got_a.size() == rw2)) start = 1'b1;
      if (DumpValid && DumpReady) begin
        got_a.push_back(DumpAddr);
        got_d.push_back(DumpData);
      end
      pv = DumpValid && !DumpReady; pa = DumpAddr; pd = DumpData;
    end
    timed_out = 1'b1;
  endtask

  task automatic check_words(input string name);
    int bad;
    bad = 0;
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL %s: timeout, dump never finished", name);
    end
    checks++;
    if (got_a.size() !== exp_a.size()) begin
      errors++;
      $display("FAIL %s count: got %0d words, expected %0d", name, got_a.size(), exp_a.size());
    end else begin
      for (int i = 0; i < exp_a.size(); i++)
        if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
          if (bad == 0)
            $display("FAIL %s word %0d: got addr %0d data %h, expected addr %0d data %h",
                     name, i, got_a[i], got_d[i], exp_a[i], exp_d[i]);
          bad++;
        end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s content: %0d words wrong, expected 0", name, bad);
      end
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL %s done: got %0d pulses, expected 1", name, done_cnt);
    end
    checks++;
    if (stab_err !== 0) begin
      errors++;
      $display("FAIL %s stability: got %0d changes while stalled, expected 0", name, stab_err);
    end
`ifdef REG_DUMP_SKIP_ZERO_EN
    checks++;
    if (DumpCount !== (AW+1)'(exp_a.size())) begin
      errors++;
      $display("FAIL %s DumpCount: got %0d, expected %0d", name, DumpCount, exp_a.size());
    end
`endif
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({DumpValid, busy, done, rs1, rs2, DumpAddr, DumpData} !== '0) begin
      errors++;
      $display("FAIL reset: valid=%b busy=%b done=%b rs1=%0d rs2=%0d addr=%0d data=%h, expected all 0",
               DumpValid, busy, done, rs1, rs2, DumpAddr, DumpData);
    end
  endtask

  task automatic test_full_dump;
    logic [DW-1:0] snap [NR];
    for (int i = 0; i < NR; i++) regs[i] = DW'(i * 32'h11);
    snap = regs;
    build_exp(snap);
    run_dump(100, -1, -1, -1, '0);
    check_words("full_dump");
`ifndef REG_DUMP_SKIP_ZERO_EN
    checks++;
    if (done_rel !== 3 * NR / 2 + 1) begin
      errors++;
      $display("FAIL full_dump done timing: got edge %0d, expected %0d", done_rel, 3 * NR / 2 + 1);
    end
`endif
  endtask

  task automatic test_random_ready;
    logic [DW-1:0] snap [NR];
    for (int i = 0; i < NR; i++) regs[i] = $urandom;
    snap = regs;
    build_exp(snap);
    run_dump(40, -1, -1, -1, '0);
    check_words("random_ready");
  endtask

  task automatic test_restart_ignored;
    logic [DW-1:0] snap [NR];
    for (int i = 0; i < NR; i++) regs[i] = $urandom | 32'h1;
    snap = regs;
    build_exp(snap);
    run_dump(60, 5, 20, -1, '0);
    check_words("restart_ignored");
  endtask

  task automatic test_snapshot;
    logic [DW-1:0] snap [NR];
    for (int i = 0; i < NR; i++) regs[i] = $urandom | 32'h100;
    snap = regs;
    build_exp(snap);
    run_dump(50, -1, -1, 6, 32'hDEAD);
    check_words("snapshot_old");
    snap[6] = 32'hDEAD;
    build_exp(snap);
    run_dump(100, -1, -1, -1, '0);
    check_words("snapshot_new");
  endtask

  task automatic test_abort;
    logic [DW-1:0] snap [NR];
    bit hit;
    int dpulse;
    for (int i = 0; i < NR; i++) regs[i] = $urandom | 32'h1;
    hit = 0; dpulse = 0;
    @(negedge clk);
    start = 1'b1; DumpReady = 1'b1;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (DumpValid && DumpAddr == AW'(15)) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL abort: SEND_B of pair 7 not reached, expected within 200 cycles");
    end
    DumpReady = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({DumpValid, busy, done, rs1, rs2} !== '0) begin
      errors++;
      $display("FAIL abort outputs: valid=%b busy=%b done=%b rs1=%0d rs2=%0d, expected all 0",
               DumpValid, busy, done, rs1, rs2);
    end
    repeat (4) begin
      @(negedge clk);
      if (done) dpulse++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) dpulse++;
    end
    checks++;
    if (dpulse !== 0) begin
      errors++;
      $display("FAIL abort done: got %0d done/busy cycles after abort, expected 0", dpulse);
    end
    snap = regs;
    build_exp(snap);
    run_dump(70, -1, -1, -1, '0);
    check_words("after_abort");
  endtask

`ifdef REG_DUMP_SKIP_ZERO_EN
  task automatic test_skip_zero;
    logic [DW-1:0] snap [NR];
    for (int i = 0; i < NR; i++) regs[i] = '0;
    regs[3] = 32'h33; regs[4] = $urandom | 32'h1; regs[31] = 32'hCAFE;
    snap = regs;
    build_exp(snap);
    checks++;
    if (exp_a.size() !== 3) begin
      errors++;
      $display("FAIL skip model: got %0d expected words, expected 3", exp_a.size());
    end
    run_dump(50, -1, -1, -1, '0);
    check_words("skip_three");
    for (int i = 0; i < NR; i++) regs[i] = '0;
    snap = regs;
    build_exp(snap);
    run_dump(100, -1, -1, -1, '0);
    check_words("skip_all_zero");
  endtask
`endif

  initial begin
    for (int i = 0; i < NR; i++) regs[i] = '0;
    test_reset;
    test_full_dump;
    test_random_ready;
    test_restart_ignored;
    test_snapshot;
    test_abort;
`ifdef REG_DUMP_SKIP_ZERO_EN
    test_skip_zero;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
